fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
Parametrised successor to the single-group fetch stage. It takes a FETCH_WIDTH-lane group from the I-cache side and masks lanes following the first predicted-taken lane. Surviving lanes are compacted into a DEPTH-entry circular instruction queue. The queue drains up to DECODE_WIDTH instructions per cycle to pre-decode, which decouples I-cache miss stalls from pre-decode back-pressure.

Parameters:
FETCH_WIDTH, 2, lanes per incoming fetch group (1..8)
DECODE_WIDTH, 2, max instructions presented downstream per cycle (1..FETCH_WIDTH)
DEPTH, 8, queue entries; power of two, >= FETCH_WIDTH+DECODE_WIDTH
PC_W, 32, PC width
INSN_W, 32, instruction width
INSN_BYTES, 4, PC increment per instruction

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low
in_valid  in  FETCH_WIDTH  lane valid; valid lanes contiguous from lane 0
in_pc  in  FETCH_WIDTH*PC_W  lane PCs
in_insn  in  FETCH_WIDTH*INSN_W  I-cache data per lane
ic_hit  in  1  I-cache hit for lane 0 address
bp_taken  in  FETCH_WIDTH  per-lane predicted taken
bp_target  in  PC_W  predicted target of first taken lane
clear  in  1  flush (branch mispredict/exception)
in_ready  out  1  queue can accept a full group this cycle
bubble_req  out  1  request upstream stall: I-cache miss
ic_miss_pulse  out  1  one-cycle pulse at start of a miss episode
out_valid  out  DECODE_WIDTH  downstream entry valid; contiguous from slot 0
out_pc  out  DECODE_WIDTH*PC_W  entry PCs
out_insn  out  DECODE_WIDTH*INSN_W  entry instructions
out_pred_taken  out  DECODE_WIDTH  entry predicted taken
out_pred_addr  out  DECODE_WIDTH*PC_W  predicted next PC
out_ready  in  1  downstream consumes all presented valid entries
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset (rst=0, async): head=tail=count=0, miss-episode flag=0. All outputs 0, except in_ready=1.
- Lane masking: k = lowest lane with in_valid&bp_taken. Lanes >k are dropped. Lane k gets pred_taken=1 and pred_addr=bp_target. Other kept lanes get pred_taken=0 and pred_addr=pc+INSN_BYTES, modulo 2^PC_W.
- in_ready = (DEPTH - count) >= FETCH_WIDTH. Computed from registered count only; no same-cycle credit from a pop.
- push = in_ready & in_valid[0] & ic_hit & !clear. Kept lanes are written at tail..tail+n-1 mod DEPTH. tail += n, where n = number of kept lanes.
- bubble_req = in_valid[0] & !ic_hit (combinational). When in_valid[0]=0, ic_hit is ignored.
- Miss-episode flag is set on the cycle after bubble_req=1 and cleared when bubble_req=0.
- ic_miss_pulse = bubble_req & !flag & !clear. Exactly one pulse per contiguous miss episode.
- Output: slot i is valid iff i < count. Data is read from entry (head+i) mod DEPTH. Outputs are registered-state only; no input-to-output bypass.
- pop = out_ready & !clear. head += m and count -= m, where m = min(count, DECODE_WIDTH).
- Simultaneous push+pop: count_next = count + n - m.
- Latency: a group pushed in cycle t appears at out_* in cycle t+1 at the earliest.
- clear: next cycle head=tail=count=0 and the flag clears. Same-cycle push and pop are discarded. clear has priority over all other events.
- Pointers are $clog2(DEPTH) bits and wrap naturally. A group spanning the wrap point is written correctly.
- Overflow/underflow are impossible by construction. Assertion required: count <= DEPTH.
- Reset asserted mid-operation: immediate return to reset state; queue contents are don't-care.

Test Plan:
- Reset then three groups {pc 0x100,0x104} with bp_taken=00, ic_hit=1, out_ready=0 -> count 2,4,6; in_ready=0 once count=7 or 8 (here stays 1 at 6). out_pc slot0=0x100, slot1=0x104, pred_addr 0x104/0x108.
- Group {0x200,0x204}, bp_taken=01, bp_target=0x400 -> only 0x200 enqueued, pred_taken=1, pred_addr=0x400, count+=1.
- in_valid=11, ic_hit=0 for 5 cycles then 1 -> bubble_req high 5 cycles, ic_miss_pulse exactly once (first cycle), no push during miss, push on 6th cycle.
- Fill to count=8 with out_ready=0 -> in_ready=0 and no push. Then out_ready=1 with concurrent groups -> steady state count constant (push 2, pop 2); entries emerge in program order across the pointer wrap at 7->0.
- count=5, clear=1 with simultaneous valid push and out_ready=1 -> next cycle count=0, out_valid=00, in_ready=1; nothing from that cycle retained.
- Async reset pulse mid-stream (count=4) -> outputs zero immediately without clock edge; in_ready=1 after release.

Source files
------------

// File: rtl/fetch_queue_stage_if.sv
`timescale 1ns/1ps
// Bundle of fetch-side inputs, pre-decode outputs and queue status for fetch_queue_stage.
// Latency: none (wires only).
// Backpressure: in_ready toward I-cache side, out_ready from pre-decode.
interface fetch_queue_stage_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PC_W         = 32,
  parameter int INSN_W       = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // fetch side
  logic [FETCH_WIDTH-1:0]        in_valid;
  logic [FETCH_WIDTH*PC_W-1:0]   in_pc;
  logic [FETCH_WIDTH*INSN_W-1:0] in_insn;
  logic                          ic_hit;
  logic [FETCH_WIDTH-1:0]        bp_taken;
  logic [PC_W-1:0]               bp_target;
  logic                          clear;
  logic                          in_ready;
  logic                          bubble_req;
  logic                          ic_miss_pulse;

  // pre-decode side
  logic [DECODE_WIDTH-1:0]        out_valid;
  logic [DECODE_WIDTH*PC_W-1:0]   out_pc;
  logic [DECODE_WIDTH*INSN_W-1:0] out_insn;
  logic [DECODE_WIDTH-1:0]        out_pred_taken;
  logic [DECODE_WIDTH*PC_W-1:0]   out_pred_addr;
  logic                           out_ready;
  logic [CNT_W-1:0]               count;

  // environment driving the queue
  modport master (
    output in_valid, in_pc, in_insn, ic_hit, bp_taken, bp_target, clear, out_ready,
    input  in_ready, bubble_req, ic_miss_pulse,
    input  out_valid, out_pc, out_insn, out_pred_taken, out_pred_addr, count
  );

  // the queue itself
  modport slave (
    input  in_valid, in_pc, in_insn, ic_hit, bp_taken, bp_target, clear, out_ready,
    output in_ready, bubble_req, ic_miss_pulse,
    output out_valid, out_pc, out_insn, out_pred_taken, out_pred_addr, count
  );
endinterface

// File: rtl/fetch_queue_stage.sv
`timescale 1ns/1ps
// Fetch stage: masks lanes after the first predicted-taken lane and compacts survivors into a circular queue.
// Latency: a group pushed in cycle t is visible at out_* in cycle t+1; outputs come from registered state only.
// Backpressure: in_ready only when a full group fits (registered count); pre-decode drains up to DECODE_WIDTH when out_ready.
module fetch_queue_stage #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int PC_W         = 32,
  parameter int INSN_W       = 32,
  parameter int INSN_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_queue_stage_if.slave    io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_addr;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              miss_q, miss_d;

  entry_t            lane_ent [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] keep;
  logic              taken_seen;
  logic [CNT_W-1:0]  n_keep;
  logic [CNT_W-1:0]  push_n, pop_m;
  logic              in_ready_w, bubble_w, push;

  // Lane masking: everything after the first valid taken lane is dropped; build the entry per lane.
  always_comb begin
    taken_seen = 1'b0;
    n_keep     = '0;
    keep       = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      keep[j]                = io.in_valid[j] & ~taken_seen;
      lane_ent[j].pc         = io.in_pc[j*PC_W +: PC_W];
      lane_ent[j].insn       = io.in_insn[j*INSN_W +: INSN_W];
      lane_ent[j].pred_taken = keep[j] & io.bp_taken[j];
      lane_ent[j].pred_addr  = lane_ent[j].pred_taken ? io.bp_target
                                                      : lane_ent[j].pc + PC_W'(INSN_BYTES);
      if (keep[j]) n_keep = n_keep + CNT_W'(1);
      taken_seen = taken_seen | (io.in_valid[j] & io.bp_taken[j]);
    end
  end

  // Handshake decisions; bubble_req is forced low while reset is held so every output reads zero.
  always_comb begin
    in_ready_w = (count_q <= CNT_W'(DEPTH - FETCH_WIDTH));
    bubble_w   = rst & io.in_valid[0] & ~io.ic_hit;
    push       = in_ready_w & io.in_valid[0] & io.ic_hit & ~io.clear;
    push_n     = push ? n_keep : '0;
    if (io.out_ready && !io.clear)
      pop_m = (count_q < CNT_W'(DECODE_WIDTH)) ? count_q : CNT_W'(DECODE_WIDTH);
    else
      pop_m = '0;
  end

  // Queue storage write: kept lanes land at tail..tail+n-1, wrapping through the pointer width.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) mem_d[e] = mem_q[e];
    if (push) begin
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (keep[j]) mem_d[tail_q + PTR_W'(j)] = lane_ent[j];
      end
    end
  end

  // Pointer, occupancy and miss-episode next state; clear overrides push and pop.
  always_comb begin
    head_d  = head_q + pop_m[PTR_W-1:0];
    tail_d  = tail_q + push_n[PTR_W-1:0];
    count_d = count_q + push_n - pop_m;
    miss_d  = bubble_w & ~io.clear;
    if (io.clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state, asynchronously reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      miss_q  <= miss_d;
    end
  end

  // Queue contents carry no reset; invalid slots are masked on the way out.
  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
  end

  // Output slots read head+i from registered state; data is zeroed on invalid slots.
  always_comb begin
    entry_t ent;
    logic   vld;
    io.out_valid      = '0;
    io.out_pc         = '0;
    io.out_insn       = '0;
    io.out_pred_taken = '0;
    io.out_pred_addr  = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      vld = (CNT_W'(i) < count_q);
      ent = mem_q[head_q + PTR_W'(i)];
      if (vld) begin
        io.out_valid[i]                  = 1'b1;
        io.out_pc[i*PC_W +: PC_W]        = ent.pc;
        io.out_insn[i*INSN_W +: INSN_W]  = ent.insn;
        io.out_pred_taken[i]             = ent.pred_taken;
        io.out_pred_addr[i*PC_W +: PC_W] = ent.pred_addr;
      end
    end
  end

  // Status outputs toward the I-cache side.
  always_comb begin
    io.in_ready      = in_ready_w;
    io.bubble_req    = bubble_w;
    io.ic_miss_pulse = bubble_w & ~miss_q & ~io.clear;
    io.count         = count_q;
  end

  // Occupancy can never exceed the queue size.
  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_fetch_queue_stage.sv
`timescale 1ns/1ps
// Testbench for fetch_queue_stage: directed groups, scoreboard queue of expected entries, negedge monitor.
// Latency: expected entries are queued right after the accepting clock edge.
// Backpressure: out_ready and clear are driven by the stimulus; the monitor pops only what the DUT consumes.
module tb_fetch_queue_stage;
  localparam int FW = 2;
  localparam int DW = 2;
  localparam int D  = 8;
  localparam logic [31:0] K = 32'hA500_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_stage_if #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(D), .PC_W(32), .INSN_W(32)) bus ();

  fetch_queue_stage #(.FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(D),
                      .PC_W(32), .INSN_W(32), .INSN_BYTES(4)) dut (
    .clk (clk),
    .rst (rst_n),
    .io  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        tk;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle();
    bus.in_valid  = '0;
    bus.in_pc     = '0;
    bus.in_insn   = '0;
    bus.bp_taken  = '0;
    bus.bp_target = '0;
    bus.ic_hit    = 1'b1;
    bus.clear     = 1'b0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [1:0] tk,
                       input logic [31:0] tgt, input logic hit, input logic clr);
    bus.in_valid  = v;
    bus.in_pc     = {pc0 + 32'd4, pc0};
    bus.in_insn   = {(pc0 + 32'd4) ^ K, pc0 ^ K};
    bus.bp_taken  = tk;
    bus.bp_target = tgt;
    bus.ic_hit    = hit;
    bus.clear     = clr;
  endtask

  // Clock the driven group in; exp_n is the hand-computed number of lanes the DUT must keep.
  task automatic step(input int exp_n);
    exp_t e;
    @(posedge clk);
    #1;
    for (int j = 0; j < exp_n; j++) begin
      e.pc   = bus.in_pc[j*32 +: 32];
      e.insn = e.pc ^ K;
      e.tk   = bus.bp_taken[j];
      e.addr = e.tk ? bus.bp_target : e.pc + 32'd4;
      exp_q.push_back(e);
    end
    if (bus.clear) exp_q.delete();
    idle();
  endtask

  // Monitor: occupancy and slot validity every cycle, then pop and compare whatever pre-decode consumes.
  initial begin : monitor
    int   sz;
    int   m;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        sz = exp_q.size();
        m  = (sz < DW) ? sz : DW;
        chk("mon_count", 64'(bus.count), 64'(sz));
        chk("mon_out_valid", 64'(bus.out_valid), 64'((1 << m) - 1));
        if (bus.out_ready && !bus.clear) begin
          for (int i = 0; i < m; i++) begin
            e = exp_q.pop_front();
            chk("slot_pc_addr", {bus.out_pc[i*32 +: 32], bus.out_pred_addr[i*32 +: 32]}, {e.pc, e.addr});
            chk("slot_insn_tk", {31'd0, bus.out_pred_taken[i], bus.out_insn[i*32 +: 32]}, {31'd0, e.tk, e.insn});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b0;
    // reset state, with a would-be miss on the inputs
    bus.in_valid = 2'b01;
    bus.ic_hit   = 1'b0;
    #3;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_bubble", 64'(bus.bubble_req), 64'd0);
    chk("rst_pulse", 64'(bus.ic_miss_pulse), 64'd0);
    idle();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // three plain groups, no consumption
    drive(2'b11, 32'h100, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    chk("g1_count", 64'(bus.count), 64'd2);
    drive(2'b11, 32'h108, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    chk("g2_count", 64'(bus.count), 64'd4);
    drive(2'b11, 32'h110, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    chk("g3_count", 64'(bus.count), 64'd6);
    chk("g3_in_ready", 64'(bus.in_ready), 64'd1);
    chk("g3_slot0_pc", 64'(bus.out_pc[31:0]), 64'h100);
    chk("g3_slot1_addr", 64'(bus.out_pred_addr[63:32]), 64'h108);

    // taken in lane 0: lane 1 dropped
    drive(2'b11, 32'h200, 2'b01, 32'h400, 1'b1, 1'b0); step(1);
    chk("tk_count", 64'(bus.count), 64'd7);
    chk("tk_in_ready", 64'(bus.in_ready), 64'd0);
    drive(2'b11, 32'h280, 2'b00, 32'h0, 1'b1, 1'b0); step(0);
    chk("nr_count", 64'(bus.count), 64'd7);

    // drain to empty
    bus.out_ready = 1'b1;
    repeat (4) step(0);
    chk("drain_count", 64'(bus.count), 64'd0);
    bus.out_ready = 1'b0;

    // miss episode: five miss cycles, then a hit
    drive(2'b11, 32'h500, 2'b00, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("miss_bubble", 64'(bus.bubble_req), 64'd1);
      chk("miss_pulse", 64'(bus.ic_miss_pulse), (c == 0) ? 64'd1 : 64'd0);
      @(posedge clk);
      #1;
    end
    bus.ic_hit = 1'b1;
    @(negedge clk);
    chk("hit_bubble", 64'(bus.bubble_req), 64'd0);
    chk("hit_pulse", 64'(bus.ic_miss_pulse), 64'd0);
    step(2);
    chk("hit_count", 64'(bus.count), 64'd2);

    // fill to full, then refuse a group
    drive(2'b11, 32'h600, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    drive(2'b11, 32'h608, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    drive(2'b11, 32'h610, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    chk("full_count", 64'(bus.count), 64'd8);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    drive(2'b11, 32'h618, 2'b00, 32'h0, 1'b1, 1'b0); step(0);
    chk("full_hold", 64'(bus.count), 64'd8);

    // start draining: full cycle pops only, then steady push 2 / pop 2 across the wrap
    bus.out_ready = 1'b1;
    drive(2'b11, 32'h618, 2'b00, 32'h0, 1'b1, 1'b0); step(0);
    chk("pop_only_count", 64'(bus.count), 64'd6);
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 32'h618 + 32'(8 * k), 2'b00, 32'h0, 1'b1, 1'b0); step(2);
      chk("steady_count", 64'(bus.count), 64'd6);
    end

    // taken in lane 1 (both lanes kept) while popping: 6 - 2 + 2 = 6, then taken lane 0: 6 - 2 + 1 = 5
    drive(2'b11, 32'h700, 2'b10, 32'h880, 1'b1, 1'b0); step(2);
    chk("tk1_count", 64'(bus.count), 64'd6);
    drive(2'b11, 32'h720, 2'b01, 32'h800, 1'b1, 1'b0); step(1);
    chk("five_count", 64'(bus.count), 64'd5);

    // clear with a simultaneous push and pop
    drive(2'b11, 32'h900, 2'b00, 32'h0, 1'b1, 1'b1); step(0);
    chk("clr_count", 64'(bus.count), 64'd0);
    chk("clr_out_valid", 64'(bus.out_valid), 64'd0);
    chk("clr_in_ready", 64'(bus.in_ready), 64'd1);
    step(0);
    chk("clr_after_count", 64'(bus.count), 64'd0);

    // async reset mid-stream at occupancy 4
    bus.out_ready = 1'b0;
    drive(2'b11, 32'hA00, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    drive(2'b11, 32'hA08, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    chk("pre_rst_count", 64'(bus.count), 64'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_pc", bus.out_pc, 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // queue works again after reset
    drive(2'b11, 32'hB00, 2'b00, 32'h0, 1'b1, 1'b0); step(2);
    chk("post_rst_count", 64'(bus.count), 64'd2);
    chk("post_rst_slot0", 64'(bus.out_pc[31:0]), 64'hB00);
    bus.out_ready = 1'b1;
    step(0);
    step(0);
    chk("final_count", 64'(bus.count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
